// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared choice encodings, round FSM states and outcome helpers
package rps_pkg;

  // Choice codes as held in each player's latch
  localparam logic [1:0] ROCK     = 2'd0;
  localparam logic [1:0] PAPER    = 2'd1;
  localparam logic [1:0] SCISSORS = 2'd2;

  // One-hot button encoding
  localparam logic [2:0] SEL_ROCK     = 3'b001;
  localparam logic [2:0] SEL_PAPER    = 3'b010;
  localparam logic [2:0] SEL_SCISSORS = 3'b100;

  localparam int WIN_SCORE_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2,
    SCORED  = 2'd3
  } state_t;

  // Round result: bit0 = player 1 scores, bit1 = player 2 scores, 0 = tie
  localparam logic [1:0] OUT_TIE = 2'b00;
  localparam logic [1:0] OUT_P1  = 2'b01;
  localparam logic [1:0] OUT_P2  = 2'b10;

  function automatic logic sel_valid(input logic [2:0] sel);
    return (sel == SEL_ROCK) || (sel == SEL_PAPER) || (sel == SEL_SCISSORS);
  endfunction

  function automatic logic [1:0] sel_to_choice(input logic [2:0] sel);
    logic [1:0] c;
    case (sel)
      SEL_PAPER:    c = PAPER;
      SEL_SCISSORS: c = SCISSORS;
      default:      c = ROCK;
    endcase
    return c;
  endfunction

  // (p1 - p2) mod 3 computed as p1 - p2 + 3, which stays in 1..5
  function automatic logic [1:0] outcome(input logic [1:0] c1, input logic [1:0] c2);
    logic [2:0] s;
    logic [1:0] r;
    s = {1'b0, c1} + 3'd3 - {1'b0, c2};
    case (s)
      3'd1, 3'd4: r = OUT_P1;
      3'd2, 3'd5: r = OUT_P2;
      default:    r = OUT_TIE;
    endcase
    return r;
  endfunction

  // One-hot combination, bit index 3*p1 + p2
  function automatic logic [8:0] combo_onehot(input logic [1:0] c1, input logic [1:0] c2);
    logic [3:0] idx;
    idx = {1'b0, c1, 1'b0} + {2'b00, c1} + {2'b00, c2};
    return 9'd1 << idx;
  endfunction

endpackage

// File: rtl/choice_latch.sv
// rtl/choice_latch.sv - per-player one-hot validity check and choice lock register
module choice_latch
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       open,
  input  logic       en,
  input  logic [2:0] sel,
  output logic       locked,
  output logic [1:0] choice,
  output logic       locked_nx,
  output logic [1:0] choice_nx
);

  // Next lock state is exported so the top can detect the final lock on the same edge
  always_comb begin
    locked_nx = locked;
    choice_nx = choice;
    if (open) begin
      locked_nx = 1'b0;
      choice_nx = ROCK;
    end else if (en && !locked && sel_valid(sel)) begin
      locked_nx = 1'b1;
      choice_nx = sel_to_choice(sel);
    end
  end

  // Lock register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked <= 1'b0;
      choice <= ROCK;
    end else begin
      locked <= locked_nx;
      choice <= choice_nx;
    end
  end

endmodule

// File: rtl/rps_round_datapath.sv
// rtl/rps_round_datapath.sv - round FSM, combination/outcome logic and saturating scores
module rps_round_datapath
  import rps_pkg::*;
#(
  parameter int WIN_SCORE = WIN_SCORE_DEF,
  parameter int SCORE_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               arm_i,
  input  logic               score_i,
  input  logic [2:0]         p1_sel,
  input  logic [2:0]         p2_sel,
  output logic [8:0]         combo_o,
  output logic               game_over_o,
  output logic               p1_winner_o,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               p1_locked,
  output logic               p2_locked
);

  localparam logic [SCORE_W-1:0] WIN_S = WIN_SCORE[SCORE_W-1:0];
  localparam logic [SCORE_W:0]   WIN_X = WIN_SCORE[SCORE_W:0];

  state_t     state, state_nx;
  logic       do_score, do_arm, open, en, fin;
  logic       p1_locked_nx, p2_locked_nx;
  logic [1:0] p1_choice, p2_choice, p1_choice_nx, p2_choice_nx;
  logic [1:0] pend, res_nx;
  logic       go_nx;

  // Command decode with clear > score > arm priority
  assign do_score = !clear_i && score_i && (state == READY);
  assign do_arm   = !clear_i && arm_i && ((state == IDLE) || (state == SCORED));
  assign open     = clear_i || do_arm;
  assign en       = !clear_i && (state == COLLECT);
  assign fin      = en && p1_locked_nx && p2_locked_nx;

  choice_latch u_p1 (
    .clk       (clk),
    .reset     (reset),
    .open      (open),
    .en        (en),
    .sel       (p1_sel),
    .locked    (p1_locked),
    .choice    (p1_choice),
    .locked_nx (p1_locked_nx),
    .choice_nx (p1_choice_nx)
  );

  choice_latch u_p2 (
    .clk       (clk),
    .reset     (reset),
    .open      (open),
    .en        (en),
    .sel       (p2_sel),
    .locked    (p2_locked),
    .choice    (p2_choice),
    .locked_nx (p2_locked_nx),
    .choice_nx (p2_choice_nx)
  );

  // Projected outcome of the round being locked in
  always_comb begin
    res_nx = outcome(p1_choice_nx, p2_choice_nx);
    go_nx  = 1'b0;
    if (res_nx == OUT_P1)
      go_nx = ({1'b0, p1_score} + 1'b1) >= WIN_X;
    else if (res_nx == OUT_P2)
      go_nx = ({1'b0, p2_score} + 1'b1) >= WIN_X;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (clear_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, SCORED: if (arm_i)   state_nx = COLLECT;
        COLLECT:      if (fin)     state_nx = READY;
        READY:        if (score_i) state_nx = SCORED;
        default:                   state_nx = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Combination, game-over flags and scores; once the game is over the flags hold until clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      combo_o     <= '0;
      game_over_o <= 1'b0;
      p1_winner_o <= 1'b0;
      p1_score    <= '0;
      p2_score    <= '0;
      pend        <= OUT_TIE;
    end else if (clear_i) begin
      combo_o     <= '0;
      game_over_o <= 1'b0;
      p1_winner_o <= 1'b0;
      p1_score    <= '0;
      p2_score    <= '0;
      pend        <= OUT_TIE;
    end else if (fin) begin
      combo_o <= combo_onehot(p1_choice_nx, p2_choice_nx);
      pend    <= res_nx;
      if (!game_over_o) begin
        game_over_o <= go_nx;
        p1_winner_o <= (res_nx == OUT_P1);
      end
    end else if (do_score) begin
      combo_o <= '0;
      if (pend == OUT_P1 && p1_score < WIN_S) p1_score <= p1_score + 1'b1;
      if (pend == OUT_P2 && p2_score < WIN_S) p2_score <= p2_score + 1'b1;
    end
  end

endmodule

// File: tb/tb_rps_round_datapath.sv
// tb/tb_rps_round_datapath.sv - self-checking bench for rps_round_datapath
module tb_rps_round_datapath;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_i = 1'b0, arm_i = 1'b0, score_i = 1'b0;
  logic [2:0] p1_sel = 3'b000, p2_sel = 3'b000;
  logic [8:0] combo_o;
  logic       game_over_o, p1_winner_o, p1_locked, p2_locked;
  logic [1:0] p1_score, p2_score;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  int m_p1, m_p2, m_go, m_win, m_d;

  rps_round_datapath #(.WIN_SCORE(3), .SCORE_W(2)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .clear_i     (clear_i),
    .arm_i       (arm_i),
    .score_i     (score_i),
    .p1_sel      (p1_sel),
    .p2_sel      (p2_sel),
    .combo_o     (combo_o),
    .game_over_o (game_over_o),
    .p1_winner_o (p1_winner_o),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .p1_locked   (p1_locked),
    .p2_locked   (p2_locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s1;
    logic [2:0] s2;
    int         idx;
    int         e1;
    int         e2;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    m_p1 = 0; m_p2 = 0; m_go = 0; m_win = 0;
  endtask

  task automatic do_arm;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic do_score;
    score_i = 1'b1;
    tick();
    score_i = 1'b0;
    if (m_d == 1 && m_p1 < 3) m_p1++;
    if (m_d == 2 && m_p2 < 3) m_p2++;
  endtask

  function automatic int sel2c(input logic [2:0] s);
    return (s == 3'b001) ? 0 : (s == 3'b010) ? 1 : 2;
  endfunction

  function automatic logic [2:0] c2sel(input int c);
    logic [2:0] s;
    s = 3'b001;
    return s << c;
  endfunction

  // Model: resolve a round once both choices are known
  task automatic model_lock(input int c1, input int c2);
    m_d = (((c1 - c2) % 3) + 3) % 3;
    if (m_go == 0) begin
      if (m_d == 1)      begin m_go = (m_p1 + 1 >= 3); m_win = 1; end
      else if (m_d == 2) begin m_go = (m_p2 + 1 >= 3); m_win = 0; end
      else               begin m_go = 0; m_win = 0; end
    end
  endtask

  task automatic chk_ready(input string tag, input int c1, input int c2);
    logic [8:0] one;
    one = 9'd1;
    chk({tag, " combo"}, combo_o, one << (3 * c1 + c2));
    chk({tag, " game_over"}, game_over_o, m_go);
    chk({tag, " p1_winner"}, p1_winner_o, m_win);
  endtask

  task automatic chk_scores(input string tag);
    chk({tag, " p1_score"}, p1_score, m_p1);
    chk({tag, " p2_score"}, p2_score, m_p2);
  endtask

  // Simple round: both players press on the same edge
  task automatic round(input logic [2:0] s1, input logic [2:0] s2);
    do_arm();
    p1_sel = s1; p2_sel = s2;
    tick();
    p1_sel = 3'b000; p2_sel = 3'b000;
    model_lock(sel2c(s1), sel2c(s2));
  endtask

  initial begin
    vecs[0] = '{3'b001, 3'b001, 0, 0, 0};
    vecs[1] = '{3'b001, 3'b010, 1, 0, 1};
    vecs[2] = '{3'b001, 3'b100, 2, 1, 0};
    vecs[3] = '{3'b010, 3'b001, 3, 1, 0};
    vecs[4] = '{3'b010, 3'b010, 4, 0, 0};
    vecs[5] = '{3'b010, 3'b100, 5, 0, 1};
    vecs[6] = '{3'b100, 3'b001, 6, 0, 1};
    vecs[7] = '{3'b100, 3'b010, 7, 1, 0};
    vecs[8] = '{3'b100, 3'b100, 8, 0, 0};
    m_p1 = 0; m_p2 = 0; m_go = 0; m_win = 0; m_d = 0;

    // Reset state
    #12;
    chk("reset combo", combo_o, 0);
    chk("reset go", game_over_o, 0);
    chk("reset win", p1_winner_o, 0);
    chk("reset scores", {p1_score, p2_score}, 0);
    chk("reset locks", {p1_locked, p2_locked}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // All nine combinations from a cleared game
    for (int i = 0; i < 9; i++) begin
      do_clear();
      round(vecs[i].s1, vecs[i].s2);
      chk($sformatf("vec%0d combo", i), combo_o, 9'd1 << vecs[i].idx);
      chk($sformatf("vec%0d go", i), game_over_o, 0);
      chk($sformatf("vec%0d locks", i), {p1_locked, p2_locked}, 2'b11);
      do_score();
      chk($sformatf("vec%0d combo clr", i), combo_o, 0);
      chk($sformatf("vec%0d scores", i), {30'd0, p1_score, p2_score},
          (vecs[i].e1 << 2) | vecs[i].e2);
    end

    // Multi-hot ignored, single-hot scissors locks; tie leaves scores
    do_clear();
    do_arm();
    p1_sel = 3'b011; tick();
    chk("multihot no lock", p1_locked, 0);
    p1_sel = 3'b100; p2_sel = 3'b100; tick();
    p1_sel = 3'b000; p2_sel = 3'b000;
    model_lock(2, 2);
    chk_ready("tie", 2, 2);
    do_score();
    chk_scores("tie");

    // P1 locks rock, later paper press ignored, P2 scissors
    do_arm();
    p1_sel = 3'b001; tick();
    chk("p1 lock latency", {p1_locked, p2_locked}, 2'b10);
    chk("combo before final", combo_o, 0);
    p1_sel = 3'b010; tick();
    p2_sel = 3'b100; tick();
    p1_sel = 3'b000; p2_sel = 3'b000;
    model_lock(0, 2);
    chk_ready("second press", 0, 2);
    do_score();
    chk_scores("second press");

    // P2 wins three in a row, then saturates
    do_clear();
    for (int r = 0; r < 3; r++) begin
      round(3'b001, 3'b010);
      chk_ready($sformatf("p2 run%0d", r), 0, 1);
      do_score();
      chk_scores($sformatf("p2 run%0d", r));
    end
    chk("p2 final score", p2_score, 3);
    round(3'b001, 3'b010);
    chk("post-over go", game_over_o, 1);
    do_score();
    chk("p2 saturated", p2_score, 3);

    // clear and score together in READY with game over pending
    do_clear();
    round(3'b001, 3'b010); do_score();
    round(3'b001, 3'b010); do_score();
    round(3'b001, 3'b010);
    chk("pre-clear go", game_over_o, 1);
    clear_i = 1'b1; score_i = 1'b1;
    tick();
    clear_i = 1'b0; score_i = 1'b0;
    m_p1 = 0; m_p2 = 0; m_go = 0; m_win = 0;
    chk("clr+score scores", {p1_score, p2_score}, 0);
    chk("clr+score go", game_over_o, 0);
    chk("clr+score combo", combo_o, 0);
    p1_sel = 3'b010; p2_sel = 3'b010; tick();
    chk("idle no lock", {p1_locked, p2_locked}, 0);
    p1_sel = 3'b000; p2_sel = 3'b000;

    // Asynchronous reset in READY with buttons held
    round(3'b010, 3'b001);
    p1_sel = 3'b010; p2_sel = 3'b001;
    rst_n = 1'b0;
    #1;
    chk("async rst outputs", {combo_o, game_over_o, p1_winner_o, p1_score, p2_score,
                              p1_locked, p2_locked}, 0);
    tick();
    rst_n = 1'b1;
    m_p1 = 0; m_p2 = 0; m_go = 0; m_win = 0;
    tick(); tick(); tick();
    chk("held no lock", {p1_locked, p2_locked}, 0);
    do_arm();
    tick();
    chk("held lock after arm", {p1_locked, p2_locked}, 2'b11);
    model_lock(1, 0);
    chk_ready("held", 1, 0);
    p1_sel = 3'b000; p2_sel = 3'b000;
    do_score();
    chk_scores("held");

    // Randomised rounds against the model
    do_clear();
    for (int r = 0; r < 60; r++) begin
      int c1, c2;
      c1 = $urandom_range(0, 2);
      c2 = $urandom_range(0, 2);
      do_arm();
      if ($urandom_range(0, 2) == 0) begin
        p1_sel = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
        p2_sel = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b101;
        tick();
        chk("rand invalid", {p1_locked, p2_locked}, 0);
      end
      if ($urandom_range(0, 1) == 0) begin
        p1_sel = c2sel(c1); p2_sel = 3'b000; tick();
        p1_sel = c2sel($urandom_range(0, 2)); p2_sel = c2sel(c2); tick();
      end else begin
        p1_sel = c2sel(c1); p2_sel = c2sel(c2); tick();
      end
      p1_sel = 3'b000; p2_sel = 3'b000;
      model_lock(c1, c2);
      chk_ready($sformatf("rand%0d", r), c1, c2);
      do_score();
      chk_scores($sformatf("rand%0d", r));
      chk($sformatf("rand%0d combo clr", r), combo_o, 0);
      if (m_go != 0 && $urandom_range(0, 1) == 0) do_clear();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rps_round_datapath.md
# rps_round_datapath

Round-resolution datapath that answers the game controller FSM. It captures each player's one-hot rock/paper/scissors selection and presents the 3×3 result as a one-hot combination vector, which becomes the controller's nine combination inputs. It keeps both players' scores and drives the game-over and winner flags that the controller samples in its check and winner states. The block sits between the player button inputs and the controller.

## Interface
- WIN_SCORE, 3, points needed to win the game; scores saturate at this value
- SCORE_W, 2, score counter width; must satisfy 2^SCORE_W > WIN_SCORE
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- clear_i  in  1  level; controller in start state: zero scores, drop choices
- arm_i  in  1  level; controller in character-select state: open a new round
- score_i  in  1  controller in per-combination state: commit round result
- p1_sel  in  3  player 1 buttons, one-hot: bit0 rock, bit1 paper, bit2 scissors
- p2_sel  in  3  player 2 buttons, same encoding
- combo_o  out  9  one-hot, bit index = 3·p1_choice + p2_choice; feeds the controller's nine combination inputs in order
- game_over_o  out  1  a player has reached WIN_SCORE, or will reach it when the pending round commits
- p1_winner_o  out  1  qualifies game_over_o: 1 = player 1 wins, 0 = player 2 wins
- p1_score, p2_score  out  SCORE_W  current scores
- p1_locked, p2_locked  out  1  the player's choice is captured for this round

## Operation
- FSM states:
  - IDLE: reset and clear state.
  - COLLECT: gathering choices.
  - READY: both choices captured.
  - SCORED: result committed.
- Command priority is clear_i > score_i > arm_i.
- clear_i in any state: next state IDLE, scores 0, locks 0, combo_o 0, game_over_o 0, p1_winner_o 0.
- IDLE or SCORED with arm_i=1: next state COLLECT, both locks cleared.
- COLLECT:
  - A player's selection locks on the first sampled edge where that player's sel has exactly one bit set.
  - Zero-hot or multi-hot values are ignored.
  - Once a player is locked, further presses are ignored until the next arm.
  - arm_i is ignored in COLLECT.
- When the last outstanding lock is taken (both players may lock on the same edge), the following happens on that same edge:
  - Next state is READY.
  - combo_o is loaded with the one-hot combination.
  - game_over_o and p1_winner_o are loaded with the projected outcome of the round.
- Outcome rule with d = (p1 − p2) mod 3:
  - d=1: player 1 scores.
  - d=2: player 2 scores.
  - d=0: tie, no change.
- Projected game_over_o = the scoring player's score + 1 ≥ WIN_SCORE.
- READY with score_i=1: next state SCORED.
  - Increment the scoring player's score, saturating at WIN_SCORE.
  - combo_o clears to 0.
  - game_over_o and p1_winner_o hold their values.
- score_i outside READY is ignored.
- In SCORED, game_over_o and p1_winner_o hold until clear_i. If arm_i arrives while game_over_o=1, the round still opens; scores stay saturated.

## Timing
- Reset values: state IDLE, combo_o 0, game_over_o 0, p1_winner_o 0, p1_score 0, p2_score 0, p1_locked 0, p2_locked 0.
- All outputs are registered.
- Lock latency: a valid sel sampled at edge k gives *_locked=1 after edge k.
- combo_o and game_over_o are valid after the final lock edge. They are therefore stable for the whole cycle in which the controller sits in its per-combination state, and through its following winner state.
- Score latency: score_i sampled at edge k gives the updated score after edge k.
- combo_o is nonzero only in READY, and is then exactly one-hot.
- clear_i and score_i asserted together: clear wins, with no score update.
- Reset asserted mid-round: outputs go to reset values asynchronously. Buttons held through reset release do not lock until arm_i.

## Structure
- Shared package rps_pkg holds:
  - choice constants ROCK=0, PAPER=1, SCISSORS=2;
  - the one-hot button encoding;
  - the state enum (IDLE, COLLECT, READY, SCORED);
  - the default WIN_SCORE.
- Sub-module choice_latch, instantiated once per player.
  - Inputs: clk, reset, open (arm), sel[2:0].
  - Outputs: locked, choice[1:0].
  - Contains the one-hot validity check and the lock register.
- Top level holds the FSM, the combo/outcome logic and the saturating score counters.

## Test plan
- Reset, clear_i, arm_i; P1 paper (010), P2 rock (001) on the same edge → one cycle later combo_o bit 3, READY, game_over_o 0; score_i → p1_score 1, combo_o 0.
- P1 presses 011 (multi-hot) then 100; P2 presses 100 → P1 locks scissors only; combo_o bit 8 (tie); score_i → scores unchanged.
- P1 locks rock, then presses paper before P2 locks scissors → combo_o bit 2; P1's second press is ignored.
- P2 wins three rounds in a row → on the third READY, game_over_o=1 and p1_winner_o=0 before score_i; after score_i, p2_score=3; a further arm/round leaves p2_score at 3.
- clear_i and score_i asserted together in READY → IDLE, all scores 0, game_over_o 0.
- reset pulled low while in READY with both buttons held → all outputs 0 immediately; after release, no lock occurs until arm_i.
